// File: rtl/uart_baud_timer_if.sv
// Control and tick bundle between the UART bit-timing engine and its users.
// The master side programs the engine; the slave side is the timing engine itself.
interface uart_baud_timer_if #(
    parameter int DIV_W = 16,
    parameter int IDX_W = 4
);
    logic             enable;
    logic             trigger;
    logic             mode;
    logic [DIV_W-1:0] os_div;
    logic [IDX_W-1:0] frame_bits;
    logic             os_tick;
    logic             mid_tick;
    logic             edge_tick;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic             finish;

    modport master (
        output enable, trigger, mode, os_div, frame_bits,
        input  os_tick, mid_tick, edge_tick, bit_idx, busy, finish
    );

    modport slave (
        input  enable, trigger, mode, os_div, frame_bits,
        output os_tick, mid_tick, edge_tick, bit_idx, busy, finish
    );
endinterface

// File: rtl/uart_baud_timer.sv
// UART bit-timing engine: oversample, mid-bit and bit-edge ticks from a
// programmable divisor, for one-shot frames or free-running operation.
module uart_baud_timer #(
    parameter int DIV_W = 16,
    parameter int OSR   = 16,
    parameter int IDX_W = 4
) (
    input logic              sysclk,
    input logic              reset,
    uart_baud_timer_if.slave bus
);
    localparam int NUM_W = $clog2(OSR);
    localparam logic [NUM_W-1:0] NUM_LAST    = NUM_W'(OSR - 1);
    localparam logic [NUM_W-1:0] NUM_PRE_MID = NUM_W'(OSR / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        FREE  = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] clamp_bits(input logic [IDX_W-1:0] f);
        if (f == {IDX_W{1'b0}}) begin
            clamp_bits = IDX_W'(1);
        end else begin
            clamp_bits = f;
        end
    endfunction

    state_t           state_r, state_nxt_s;
    logic [DIV_W-1:0] div_r, div_nxt_s;
    logic [IDX_W-1:0] bits_r, bits_nxt_s;
    logic [DIV_W-1:0] os_cnt_r, os_cnt_nxt_s;
    logic [NUM_W-1:0] os_num_r, os_num_nxt_s;
    logic [IDX_W-1:0] bit_idx_r, bit_idx_nxt_s;
    logic             os_tick_r, os_tick_nxt_s;
    logic             mid_tick_r, mid_tick_nxt_s;
    logic             edge_tick_r, edge_tick_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             finish_r, finish_nxt_s;

    logic start_s, wrap_s, bit_end_s, last_bit_s;

    assign start_s    = bus.enable & (bus.trigger | bus.mode);
    assign wrap_s     = (os_cnt_r == div_r);
    assign bit_end_s  = wrap_s & (os_num_r == NUM_LAST);
    assign last_bit_s = (bit_idx_r == (bits_r - IDX_W'(1)));

    // State register
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; enable low always wins over frame progress
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = bus.mode ? FREE : FRAME;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FRAME: begin
                if (!bus.enable || (bit_end_s && last_bit_s)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FRAME;
                end
            end
            FREE: begin
                if (!bus.enable) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FREE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Counter and output next values; ticks are computed one cycle ahead and registered
    always_comb begin
        div_nxt_s       = div_r;
        bits_nxt_s      = bits_r;
        os_cnt_nxt_s    = os_cnt_r;
        os_num_nxt_s    = os_num_r;
        bit_idx_nxt_s   = bit_idx_r;
        os_tick_nxt_s   = 1'b0;
        mid_tick_nxt_s  = 1'b0;
        edge_tick_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        finish_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                bit_idx_nxt_s = {IDX_W{1'b0}};
                if (start_s) begin
                    div_nxt_s    = bus.os_div;
                    bits_nxt_s   = clamp_bits(bus.frame_bits);
                    os_cnt_nxt_s = {DIV_W{1'b0}};
                    os_num_nxt_s = {NUM_W{1'b0}};
                    busy_nxt_s   = 1'b1;
                end else begin
                    busy_nxt_s   = 1'b0;
                end
            end
            FRAME: begin
                if (!bus.enable) begin
                    bit_idx_nxt_s = {IDX_W{1'b0}};
                end else if (wrap_s) begin
                    busy_nxt_s      = 1'b1;
                    os_cnt_nxt_s    = {DIV_W{1'b0}};
                    os_num_nxt_s    = os_num_r + NUM_W'(1);
                    os_tick_nxt_s   = 1'b1;
                    mid_tick_nxt_s  = (os_num_r == NUM_PRE_MID);
                    edge_tick_nxt_s = bit_end_s;
                    if (bit_end_s && last_bit_s) begin
                        finish_nxt_s  = 1'b1;
                        busy_nxt_s    = 1'b0;
                        bit_idx_nxt_s = {IDX_W{1'b0}};
                    end else if (bit_end_s) begin
                        bit_idx_nxt_s = bit_idx_r + IDX_W'(1);
                    end else begin
                        bit_idx_nxt_s = bit_idx_r;
                    end
                end else begin
                    busy_nxt_s   = 1'b1;
                    os_cnt_nxt_s = os_cnt_r + DIV_W'(1);
                end
            end
            FREE: begin
                bit_idx_nxt_s = {IDX_W{1'b0}};
                if (!bus.enable) begin
                    busy_nxt_s = 1'b0;
                end else if (wrap_s) begin
                    // Rate changes take effect at the oversample wrap, without a restart
                    busy_nxt_s      = 1'b1;
                    div_nxt_s       = bus.os_div;
                    os_cnt_nxt_s    = {DIV_W{1'b0}};
                    os_num_nxt_s    = os_num_r + NUM_W'(1);
                    os_tick_nxt_s   = 1'b1;
                    mid_tick_nxt_s  = (os_num_r == NUM_PRE_MID);
                    edge_tick_nxt_s = bit_end_s;
                end else begin
                    busy_nxt_s   = 1'b1;
                    os_cnt_nxt_s = os_cnt_r + DIV_W'(1);
                end
            end
            default: begin
                bit_idx_nxt_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            div_r       <= {DIV_W{1'b0}};
            bits_r      <= {IDX_W{1'b0}};
            os_cnt_r    <= {DIV_W{1'b0}};
            os_num_r    <= {NUM_W{1'b0}};
            bit_idx_r   <= {IDX_W{1'b0}};
            os_tick_r   <= 1'b0;
            mid_tick_r  <= 1'b0;
            edge_tick_r <= 1'b0;
            busy_r      <= 1'b0;
            finish_r    <= 1'b0;
        end else begin
            div_r       <= div_nxt_s;
            bits_r      <= bits_nxt_s;
            os_cnt_r    <= os_cnt_nxt_s;
            os_num_r    <= os_num_nxt_s;
            bit_idx_r   <= bit_idx_nxt_s;
            os_tick_r   <= os_tick_nxt_s;
            mid_tick_r  <= mid_tick_nxt_s;
            edge_tick_r <= edge_tick_nxt_s;
            busy_r      <= busy_nxt_s;
            finish_r    <= finish_nxt_s;
        end
    end

    assign bus.os_tick   = os_tick_r;
    assign bus.mid_tick  = mid_tick_r;
    assign bus.edge_tick = edge_tick_r;
    assign bus.bit_idx   = bit_idx_r;
    assign bus.busy      = busy_r;
    assign bus.finish    = finish_r;
endmodule

// File: tb/tb_uart_baud_timer.sv
// Directed bench for uart_baud_timer: table of one-shot frames plus
// hand-written abort, held-trigger, free-run and reset sequences.
module tb_uart_baud_timer;
    localparam int DIV_W = 16;
    localparam int OSR   = 16;
    localparam int IDX_W = 4;

    logic sysclk = 1'b0;
    logic reset;

    uart_baud_timer_if #(.DIV_W(DIV_W), .IDX_W(IDX_W)) bus ();

    uart_baud_timer #(.DIV_W(DIV_W), .OSR(OSR), .IDX_W(IDX_W)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int div;
        int fbits;
        int exp_fin;
        int exp_mid;
        int exp_edge;
        int exp_os;
        int exp_mid0;
        int exp_edge0;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check(name, longint'({bus.os_tick, bus.mid_tick, bus.edge_tick,
                              bus.busy, bus.finish, bus.bit_idx}), 0);
    endtask

    // One table entry: start a frame at E0, then sample each cycle after the edge
    task automatic run_frame(input vec_t v, input int id);
        int p, fin_n, mids, edges, oss, mid0, edge0;
        int pos_err, idx_err, busy_err, busy_fin, edge_fin;
        p = v.div + 1;
        fin_n = -1; mids = 0; edges = 0; oss = 0; mid0 = -1; edge0 = -1;
        pos_err = 0; idx_err = 0; busy_err = 0; busy_fin = -1; edge_fin = -1;
        @(negedge sysclk);
        bus.os_div = DIV_W'(v.div);
        bus.frame_bits = IDX_W'(v.fbits);
        bus.mode = 1'b0;
        bus.enable = 1'b1;
        bus.trigger = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        check($sformatf("v%0d_busy_start", id), bus.busy, 1);
        bus.trigger = 1'b0;
        bus.os_div = ~bus.os_div;
        bus.frame_bits = bus.frame_bits ^ 4'hA;
        for (int n = 1; n <= v.exp_fin + 100; n++) begin
            @(negedge sysclk);
            if (bus.os_tick) begin
                oss++;
                if (n % p != 0) pos_err++;
            end
            if (bus.mid_tick) begin
                if (mid0 < 0) mid0 = n;
                if (n != (mids * OSR + OSR / 2) * p) pos_err++;
                if (bus.bit_idx != IDX_W'(mids)) idx_err++;
                mids++;
            end
            if (bus.edge_tick) begin
                if (edge0 < 0) edge0 = n;
                if (n != (edges + 1) * OSR * p) pos_err++;
                edges++;
            end
            if (bus.finish) begin
                fin_n = n;
                busy_fin = int'(bus.busy);
                edge_fin = int'(bus.edge_tick);
                break;
            end
            if (!bus.busy) busy_err++;
        end
        check($sformatf("v%0d_finish_at", id), fin_n, v.exp_fin);
        check($sformatf("v%0d_mid_count", id), mids, v.exp_mid);
        check($sformatf("v%0d_edge_count", id), edges, v.exp_edge);
        check($sformatf("v%0d_os_count", id), oss, v.exp_os);
        check($sformatf("v%0d_first_mid", id), mid0, v.exp_mid0);
        check($sformatf("v%0d_first_edge", id), edge0, v.exp_edge0);
        check($sformatf("v%0d_tick_pos_errs", id), pos_err, 0);
        check($sformatf("v%0d_bit_idx_errs", id), idx_err, 0);
        check($sformatf("v%0d_busy_drop_errs", id), busy_err, 0);
        check($sformatf("v%0d_busy_at_finish", id), busy_fin, 0);
        check($sformatf("v%0d_edge_at_finish", id), edge_fin, 1);
        bus.os_div = DIV_W'(v.div);
        repeat (2) @(negedge sysclk);
        check_quiet($sformatf("v%0d_idle_after", id));
    endtask

    initial begin : main
        int cnt, errs, first, fin_n, busy_fin;

        // Hand-computed: P = os_div+1, finish = bits*16*P, mid0 = 8P, edge0 = 16P
        vecs[0] = '{3,   10, 640,   10, 10, 160, 32,   64};
        vecs[1] = '{0,   0,  16,    1,  1,  16,  8,    16};
        vecs[2] = '{650, 2,  20832, 2,  2,  32,  5208, 10416};
        vecs[3] = '{1,   3,  96,    3,  3,  48,  16,   32};

        reset = 1'b0;
        bus.enable = 1'b0;
        bus.trigger = 1'b0;
        bus.mode = 1'b0;
        bus.os_div = '0;
        bus.frame_bits = '0;
        repeat (3) @(negedge sysclk);
        check_quiet("reset_outs");
        reset = 1'b1;
        @(negedge sysclk);
        check_quiet("idle_after_release");

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], i);
        end

        // Abort at E0+100, then retrigger from bit 0
        @(negedge sysclk);
        bus.os_div = 16'd3; bus.frame_bits = 4'd10; bus.enable = 1'b1; bus.trigger = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        bus.trigger = 1'b0;
        repeat (99) @(negedge sysclk);
        check("abort_pre_idx", bus.bit_idx, 1);
        check("abort_pre_busy", bus.busy, 1);
        bus.enable = 1'b0;
        @(negedge sysclk);
        check_quiet("abort_outs");
        bus.enable = 1'b1;
        cnt = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge sysclk);
            cnt += int'(bus.busy) + int'(bus.os_tick) + int'(bus.finish) + int'(bus.edge_tick);
        end
        check("abort_no_activity", cnt, 0);
        bus.trigger = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        bus.trigger = 1'b0;
        check("retrig_busy", bus.busy, 1);
        check("retrig_idx", bus.bit_idx, 0);
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge sysclk);
            if (bus.mid_tick && first < 0) first = n;
        end
        check("retrig_first_mid", first, 32);
        bus.enable = 1'b0;
        @(negedge sysclk);
        bus.enable = 1'b1;
        check("retrig_abort_busy", bus.busy, 0);

        // Trigger held high: no restart mid-frame, next frame one cycle after finish
        @(negedge sysclk);
        bus.os_div = 16'd0; bus.frame_bits = 4'd2; bus.trigger = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        fin_n = -1; busy_fin = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge sysclk);
            if (bus.finish) begin
                fin_n = n;
                busy_fin = int'(bus.busy);
                break;
            end
        end
        check("held_finish_at", fin_n, 32);
        check("held_busy_at_finish", busy_fin, 0);
        @(negedge sysclk);
        check("held_restart_busy", bus.busy, 1);
        check("held_restart_idx", bus.bit_idx, 0);
        bus.trigger = 1'b0;
        bus.enable = 1'b0;
        @(negedge sysclk);
        bus.enable = 1'b1;
        check_quiet("held_abort_outs");

        // Free-run at os_div=0, then switch to os_div=1
        @(negedge sysclk);
        bus.mode = 1'b1; bus.os_div = 16'd0;
        @(posedge sysclk);
        @(negedge sysclk);
        check("free_busy", bus.busy, 1);
        cnt = 0; errs = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge sysclk);
            cnt += int'(bus.os_tick);
            if (bus.edge_tick != (n % 16 == 0)) errs++;
            if (bus.bit_idx != 4'd0 || bus.finish) errs++;
        end
        check("free_os_count_div0", cnt, 64);
        check("free_edge_errs_div0", errs, 0);
        bus.os_div = 16'd1;
        cnt = 0; errs = 0; first = -1; fin_n = 0;
        for (int n = 65; n <= 128; n++) begin
            @(negedge sysclk);
            cnt += int'(bus.os_tick);
            if (bus.os_tick && (n % 2 == 0)) errs++;
            if (bus.finish) errs++;
            if (bus.edge_tick) begin
                if (first < 0) first = n;
                fin_n++;
            end
        end
        check("free_os_count_div1", cnt, 32);
        check("free_os_pos_errs_div1", errs, 0);
        check("free_first_edge_div1", first, 95);
        check("free_edge_count_div1", fin_n, 2);
        bus.mode = 1'b0;
        bus.enable = 1'b0;
        @(negedge sysclk);
        bus.enable = 1'b1;
        check_quiet("free_abort_outs");

        // Asynchronous reset mid-frame, then start on the first edge after release
        @(negedge sysclk);
        bus.os_div = 16'd3; bus.frame_bits = 4'd10; bus.trigger = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        bus.trigger = 1'b0;
        repeat (49) @(negedge sysclk);
        check("rst_pre_busy", bus.busy, 1);
        #1 reset = 1'b0;
        #1 check_quiet("rst_async_outs");
        #1;
        bus.trigger = 1'b1;
        reset = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        bus.trigger = 1'b0;
        check("rst_restart_busy", bus.busy, 1);
        check("rst_restart_idx", bus.bit_idx, 0);
        bus.enable = 1'b0;
        @(negedge sysclk);
        check_quiet("final_idle");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/uart_baud_timer.md
# uart_baud_timer

Parametrised bit-timing engine for the UART path of the pipelined CPU. It generates an oversampling tick, a mid-bit sample tick and a bit-boundary tick from a runtime-programmable divisor. It runs either one-shot frames of programmable length with a finish pulse, or free-running. It supersedes the fixed-rate, fixed-frame baud generator and serves both the transmitter (edge ticks) and the receiver (mid-bit and oversample ticks).

## Interface
Parameters:
- `DIV_W`, 16, width of the oversample divisor.
- `OSR`, 16, oversample ticks per bit; power of two, at least 4.
- `IDX_W`, 4, width of the frame-length and bit-index fields.

Ports:
- `sysclk`, in, 1, system clock; all state on the rising edge.
- `reset`, in, 1, asynchronous, active-low reset.
- `enable`, in, 1, block enable; low aborts any activity.
- `trigger`, in, 1, one-shot frame start request (level, sampled each cycle).
- `mode`, in, 1, 0 = one-shot frame, 1 = free-running; latched at start.
- `os_div`, in, DIV_W, clocks per oversample tick minus 1; latched at start.
- `frame_bits`, in, IDX_W, bit periods per frame; latched at start; 0 is treated as 1.
- `os_tick`, out, 1, one-cycle pulse every os_div+1 clocks while busy.
- `mid_tick`, out, 1, one-cycle pulse at the centre of each bit.
- `edge_tick`, out, 1, one-cycle pulse at the end of each bit.
- `bit_idx`, out, IDX_W, index of the current bit.
- `busy`, out, 1, engine running.
- `finish`, out, 1, one-cycle pulse when a one-shot frame completes.

## Operation
- States: IDLE, FRAME, FREE.
- Reset value of every output is 0, and the state is IDLE.
- Start condition: IDLE & enable & (trigger | mode).
  - On the start edge, latch mode, os_div and frame_bits (0 becomes 1).
  - Clear os_cnt, os_num (0..OSR-1) and bit_idx.
  - Enter FRAME (mode=0) or FREE (mode=1).
  - busy=1 from that edge.
- Oversample counter:
  - os_cnt increments each cycle and wraps at the latched os_div.
  - Each wrap asserts os_tick for one cycle and advances os_num modulo OSR.
  - os_div=0 gives an os_tick every cycle; this is legal.
- mid_tick: asserted together with the os_tick on which os_num becomes OSR/2.
- edge_tick: asserted together with the os_tick on which os_num wraps to 0.
  - In FRAME, bit_idx increments on every edge_tick except the last one.
- FRAME completion: the edge_tick of bit frame_bits-1 also asserts finish, and busy falls on that edge. The state returns to IDLE.
- FREE:
  - Ticks run continuously and bit_idx stays 0.
  - finish is never asserted.
  - os_div is re-sampled at each os_cnt wrap, so the rate can change without restarting.
- enable low in any non-IDLE state:
  - Next edge returns to IDLE, with busy, ticks and bit_idx at 0.
  - No finish pulse.
- Ignored inputs:
  - trigger while busy is ignored; there is no queueing.
  - mode, frame_bits and os_div changes mid-frame are ignored, except os_div in FREE.
- Back-to-back frames: a trigger still high in the cycle after finish starts a new frame. There is a minimum of one IDLE cycle between frames.
- Counter widths: os_cnt is DIV_W bits and os_num is log2(OSR) bits, with no overflow beyond the wrap points.

## Timing
- Start accepted at edge E0; busy is high from E0.
- The k-th os_tick is high in the cycle after edge E0 + k·(os_div+1).
- For bit j (0-based), with P = os_div+1:
  - mid_tick lands at E0 + (j·OSR + OSR/2)·P.
  - edge_tick lands at E0 + (j+1)·OSR·P.
- finish and busy fall coincide with the final edge_tick at E0 + frame_bits·OSR·P.
- Asynchronous reset takes effect immediately, mid-frame included. It releases to IDLE, and the first start can be accepted on the first edge after deassertion.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
- Frame timing: OSR=16, os_div=3, frame_bits=10, trigger pulse at E0.
  - 10 mid_ticks at E0+32+64j.
  - edge_ticks at E0+64(j+1).
  - bit_idx steps 0..9.
  - finish and busy fall at E0+640.
  - 160 os_ticks total.
- 100 MHz at 9600 baud: os_div=650, frame_bits=11.
  - Bit period is 10416 clocks.
  - finish at E0+114576.
- Abort: enable dropped at E0+100 (os_div=3, frame_bits=10).
  - busy=0 and ticks stop on the next edge.
  - No finish.
  - A retrigger afterwards restarts at bit_idx=0.
- Ignore and edge cases:
  - trigger held during a frame causes no restart, and a new frame starts 1 cycle after finish.
  - frame_bits=0 behaves as 1, with finish at E0+16·P.
- Free-run: mode=1, enable=1, os_div=0.
  - os_tick every cycle.
  - edge_tick every 16 cycles.
  - Changing os_div to 1 doubles the period from the next os wrap.
- Reset: assert reset low mid-frame.
  - All outputs go to 0 asynchronously.
  - After release, a start is accepted on the first edge.
